// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multicycle MIPS main control FSM
module mips_multicycle_control #(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       pc_en,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       memToReg,
    output logic       irWrite,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSource,
    output logic       illegal_op,
    output logic [3:0] state
);

    localparam logic [3:0] FETCH  = 4'd0;
    localparam logic [3:0] DECODE = 4'd1;
    localparam logic [3:0] MEMADR = 4'd2;
    localparam logic [3:0] MEMRD  = 4'd3;
    localparam logic [3:0] MEMWB  = 4'd4;
    localparam logic [3:0] MEMWR  = 4'd5;
    localparam logic [3:0] EXEC   = 4'd6;
    localparam logic [3:0] ALUWB  = 4'd7;
    localparam logic [3:0] BRANCH = 4'd8;
    localparam logic [3:0] JUMP   = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] stateReg;
    logic [3:0] nextState;
    logic       memReady;

    // With waiting disabled every memory access is treated as completing at once.
    assign memReady = MEM_WAIT_EN ? mem_ready : 1'b1;
    assign state    = stateReg;

    // State register; reset always returns to FETCH, abandoning any instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateReg <= FETCH;
        end else begin
            stateReg <= nextState;
        end
    end

    // Next-state selection; opcode only matters in DECODE and MEMADR.
    always_comb begin
        nextState = FETCH;
        case (stateReg)
            FETCH:  nextState = memReady ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_RTYPE:     nextState = EXEC;
                    OP_BEQ:       nextState = BRANCH;
                    OP_J:         nextState = JUMP;
                    default:      nextState = FETCH;
                endcase
            end
            MEMADR: nextState = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  nextState = memReady ? MEMWB : MEMRD;
            MEMWB:  nextState = FETCH;
            MEMWR:  nextState = memReady ? FETCH : MEMWR;
            EXEC:   nextState = ALUWB;
            ALUWB:  nextState = FETCH;
            BRANCH: nextState = FETCH;
            JUMP:   nextState = FETCH;
            default: nextState = FETCH;
        endcase
    end

    // Moore output decode, blanked while reset is asserted; the unused encodings fall to all-zero.
    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        memToReg    = 1'b0;
        irWrite     = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = 2'b00;
        pcSource    = 2'b00;
        illegal_op  = 1'b0;
        if (rst_n) begin
            case (stateReg)
                FETCH: begin
                    memRead = 1'b1;
                    aluSrcB = 2'b01;
                    irWrite = memReady;
                    pcWrite = memReady;
                end
                DECODE: begin
                    aluSrcB = 2'b11;
                    illegal_op = !(opcode == OP_LW || opcode == OP_SW || opcode == OP_RTYPE
                                   || opcode == OP_BEQ || opcode == OP_J);
                end
                MEMADR: begin
                    aluSrcA = 1'b1;
                    aluSrcB = 2'b10;
                end
                MEMRD: begin
                    memRead = 1'b1;
                    iorD    = 1'b1;
                end
                MEMWB: begin
                    regWrite = 1'b1;
                    memToReg = 1'b1;
                end
                MEMWR: begin
                    memWrite = 1'b1;
                    iorD     = 1'b1;
                end
                EXEC: begin
                    aluSrcA = 1'b1;
                    aluOp   = 2'b10;
                end
                ALUWB: begin
                    regWrite = 1'b1;
                    regDst   = 1'b1;
                end
                BRANCH: begin
                    aluSrcA     = 1'b1;
                    aluOp       = 2'b01;
                    pcWriteCond = 1'b1;
                    pcSource    = 2'b01;
                end
                JUMP: begin
                    pcWrite  = 1'b1;
                    pcSource = 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign pc_en = pcWrite | (pcWriteCond & zero);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb/tb_mips_multicycle_control.sv - randomized bench for mips_multicycle_control
module tb_mips_multicycle_control;

    localparam int S_FETCH  = 0;
    localparam int S_DECODE = 1;
    localparam int S_MEMADR = 2;
    localparam int S_MEMRD  = 3;
    localparam int S_MEMWB  = 4;
    localparam int S_MEMWR  = 5;
    localparam int S_EXEC   = 6;
    localparam int S_ALUWB  = 7;
    localparam int S_BRANCH = 8;
    localparam int S_JUMP   = 9;

    logic       clk = 1'b0;
    logic       rstN;
    logic       memReady;
    logic       zero;
    logic [5:0] opcode;
    logic       useDut2;

    logic pcWrite1, pcWriteCond1, pcEn1, iorD1, memRead1, memWrite1, memToReg1, irWrite1;
    logic regDst1, regWrite1, aluSrcA1, illegal1;
    logic [1:0] aluSrcB1, aluOp1, pcSource1;
    logic [3:0] state1;
    logic pcWrite2, pcWriteCond2, pcEn2, iorD2, memRead2, memWrite2, memToReg2, irWrite2;
    logic regDst2, regWrite2, aluSrcA2, illegal2;
    logic [1:0] aluSrcB2, aluOp2, pcSource2;
    logic [3:0] state2;

    logic [17:0] ctl1, ctl2, obsCtl;
    logic [3:0]  obsState;

    int nCmp = 0;
    int nBad = 0;

    always #5 clk = ~clk;

    mips_multicycle_control #(.MEM_WAIT_EN(1'b1)) dut1 (
        .clk(clk), .rst_n(rstN), .opcode(opcode), .zero(zero), .mem_ready(memReady),
        .pcWrite(pcWrite1), .pcWriteCond(pcWriteCond1), .pc_en(pcEn1), .iorD(iorD1),
        .memRead(memRead1), .memWrite(memWrite1), .memToReg(memToReg1), .irWrite(irWrite1),
        .regDst(regDst1), .regWrite(regWrite1), .aluSrcA(aluSrcA1), .aluSrcB(aluSrcB1),
        .aluOp(aluOp1), .pcSource(pcSource1), .illegal_op(illegal1), .state(state1)
    );

    mips_multicycle_control #(.MEM_WAIT_EN(1'b0)) dut2 (
        .clk(clk), .rst_n(rstN), .opcode(opcode), .zero(zero), .mem_ready(1'b0),
        .pcWrite(pcWrite2), .pcWriteCond(pcWriteCond2), .pc_en(pcEn2), .iorD(iorD2),
        .memRead(memRead2), .memWrite(memWrite2), .memToReg(memToReg2), .irWrite(irWrite2),
        .regDst(regDst2), .regWrite(regWrite2), .aluSrcA(aluSrcA2), .aluSrcB(aluSrcB2),
        .aluOp(aluOp2), .pcSource(pcSource2), .illegal_op(illegal2), .state(state2)
    );

    assign ctl1 = {pcWrite1, pcWriteCond1, pcEn1, iorD1, memRead1, memWrite1, memToReg1,
                   irWrite1, regDst1, regWrite1, aluSrcA1, aluSrcB1, aluOp1, pcSource1, illegal1};
    assign ctl2 = {pcWrite2, pcWriteCond2, pcEn2, iorD2, memRead2, memWrite2, memToReg2,
                   irWrite2, regDst2, regWrite2, aluSrcA2, aluSrcB2, aluOp2, pcSource2, illegal2};
    assign obsCtl   = useDut2 ? ctl2 : ctl1;
    assign obsState = useDut2 ? state2 : state1;

    task automatic expectEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Control word the specification's state table calls for.
    function automatic logic [17:0] expCtl(input int st, input logic rdy, input logic z, input logic ill);
        logic pw, pwc, iord, mr, mw, m2r, irw, rdst, rw, asa, il;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, iord, mr, mw, m2r, irw, rdst, rw, asa, il} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            S_FETCH:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
            S_DECODE: begin asb = 2'b11; il = ill; end
            S_MEMADR: begin asa = 1; asb = 2'b10; end
            S_MEMRD:  begin mr = 1; iord = 1; end
            S_MEMWB:  begin rw = 1; m2r = 1; end
            S_MEMWR:  begin mw = 1; iord = 1; end
            S_EXEC:   begin asa = 1; aop = 2'b10; end
            S_ALUWB:  begin rw = 1; rdst = 1; end
            S_BRANCH: begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
            S_JUMP:   begin pw = 1; psrc = 2'b10; end
            default: ;
        endcase
        return {pw, pwc, pw | (pwc & z), iord, mr, mw, m2r, irw, rdst, rw, asa, asb, aop, psrc, il};
    endfunction

    task automatic resetChecks();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            rstN = 1'b0;
            memReady = 1'b1;
            opcode = 6'($urandom);
            zero = 1'($urandom);
            #1;
            expectEq("reset ctl1", 32'(ctl1), 32'd0);
            expectEq("reset ctl2", 32'(ctl2), 32'd0);
            if (c == 1) begin
                expectEq("reset state1", 32'(state1), S_FETCH);
                expectEq("reset state2", 32'(state2), S_FETCH);
            end
        end
    endtask

    // Plans the state walk of one instruction from its opcode and wait counts, then drives and checks it.
    task automatic runInstr(input logic [5:0] opc, input logic z, input int wf, input int wm,
                            input int abortAt);
        int   stQ[$];
        logic rdyQ[$];
        logic ill;
        ill = !(opc == 6'b000000 || opc == 6'b100011 || opc == 6'b101011
                || opc == 6'b000100 || opc == 6'b000010);
        for (int i = 0; i <= wf; i++) begin stQ.push_back(S_FETCH); rdyQ.push_back(i == wf); end
        stQ.push_back(S_DECODE); rdyQ.push_back(1'b1);
        case (opc)
            6'b000000: begin stQ.push_back(S_EXEC); stQ.push_back(S_ALUWB); rdyQ.push_back(1); rdyQ.push_back(1); end
            6'b100011, 6'b101011: begin
                stQ.push_back(S_MEMADR); rdyQ.push_back(1'b1);
                for (int i = 0; i <= wm; i++) begin
                    stQ.push_back(opc == 6'b100011 ? S_MEMRD : S_MEMWR);
                    rdyQ.push_back(i == wm);
                end
                if (opc == 6'b100011) begin stQ.push_back(S_MEMWB); rdyQ.push_back(1'b1); end
            end
            6'b000100: begin stQ.push_back(S_BRANCH); rdyQ.push_back(1'b1); end
            6'b000010: begin stQ.push_back(S_JUMP); rdyQ.push_back(1'b1); end
            default: ;
        endcase
        for (int i = 0; i < stQ.size(); i++) begin
            @(negedge clk);
            if (i == abortAt) begin
                rstN = 1'b0;
                memReady = 1'b0;
                opcode = 6'($urandom);
                #1;
                expectEq($sformatf("abort state op=%b i=%0d", opc, i), 32'(obsState), stQ[i]);
                expectEq($sformatf("abort ctl op=%b i=%0d", opc, i), 32'(obsCtl), 32'd0);
                @(negedge clk);
                #1;
                expectEq($sformatf("after abort state op=%b", opc), 32'(obsState), S_FETCH);
                expectEq($sformatf("after abort ctl op=%b", opc), 32'(obsCtl), 32'd0);
                return;
            end
            rstN = 1'b1;
            opcode = (stQ[i] == S_DECODE || stQ[i] == S_MEMADR) ? opc : 6'($urandom);
            memReady = (stQ[i] == S_FETCH || stQ[i] == S_MEMRD || stQ[i] == S_MEMWR)
                       ? rdyQ[i] : 1'($urandom);
            zero = (stQ[i] == S_BRANCH) ? z : 1'($urandom);
            #1;
            expectEq($sformatf("state op=%b i=%0d", opc, i), 32'(obsState), stQ[i]);
            expectEq($sformatf("ctl op=%b i=%0d st=%0d", opc, i, stQ[i]), 32'(obsCtl),
                     32'(expCtl(stQ[i], rdyQ[i], zero, ill)));
        end
    endtask

    function automatic logic [5:0] pickOpcode();
        logic [5:0] legal [5];
        logic [5:0] op;
        legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
        if ($urandom_range(0, 5) != 0) return legal[$urandom_range(0, 4)];
        do op = 6'($urandom);
        while (op == 6'b000000 || op == 6'b100011 || op == 6'b101011 || op == 6'b000100 || op == 6'b000010);
        return op;
    endfunction

    initial begin
        rstN = 1'b0; memReady = 1'b1; zero = 1'b0; opcode = 6'd0; useDut2 = 1'b0;

        resetChecks();
        runInstr(6'b000000, 1'b0, 0, 0, -1);
        runInstr(6'b100011, 1'b0, 0, 2, -1);
        runInstr(6'b101011, 1'b0, 0, 0, -1);
        runInstr(6'b000100, 1'b1, 0, 0, -1);
        runInstr(6'b000100, 1'b0, 0, 0, -1);
        runInstr(6'b000010, 1'b0, 0, 0, -1);
        runInstr(6'b111111, 1'b0, 0, 0, -1);
        runInstr(6'b101011, 1'b0, 1, 2, 5);
        for (int n = 0; n < 80; n++) begin
            runInstr(pickOpcode(), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                     ($urandom_range(0, 7) == 0) ? $urandom_range(0, 7) : -1);
        end

        useDut2 = 1'b1;
        resetChecks();
        runInstr(6'b100011, 1'b0, 0, 0, -1);
        runInstr(6'b101011, 1'b0, 0, 0, -1);
        runInstr(6'b101011, 1'b0, 0, 0, 3);
        for (int n = 0; n < 30; n++) begin
            runInstr(pickOpcode(), 1'($urandom), 0, 0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath. Sits directly upstream of the ALU control unit and drives its 2-bit aluOp. It also generates every datapath enable and mux select from the instruction opcode, the ALU zero flag and a memory-ready handshake. It supports R-type, lw, sw, beq and j; any other opcode is flagged as illegal and aborted.

Parameters:
MEM_WAIT_EN, 1, when 1 the memory states wait on mem_ready; when 0 mem_ready is treated as constant 1.

Ports:
clk  input  1  single system clock; all state changes on the rising edge
rst_n  input  1  synchronous, active-low reset
opcode  input  6  instr[31:26] taken from the instruction register
zero  input  1  ALU zero flag, used in BRANCH
mem_ready  input  1  memory access completes this cycle
pcWrite  output  1  unconditional PC write request
pcWriteCond  output  1  conditional (beq) PC write request
pc_en  output  1  pcWrite | (pcWriteCond & zero)
iorD  output  1  memory address select: 0 = PC, 1 = ALUOut
memRead  output  1  memory read strobe
memWrite  output  1  memory write strobe
memToReg  output  1  register write-data select: 1 = MDR, 0 = ALUOut
irWrite  output  1  instruction register load
regDst  output  1  destination register select: 1 = rd, 0 = rt
regWrite  output  1  register file write enable
aluSrcA  output  1  ALU A select: 0 = PC, 1 = A register
aluSrcB  output  2  ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2
aluOp  output  2  to ALU control: 00 = add, 01 = sub, 10 = use funct
pcSource  output  2  next-PC select: 00 = ALU, 01 = ALUOut, 10 = jump target
illegal_op  output  1  one-cycle pulse on an unsupported opcode
state  output  4  current state, for debug and bench use

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9.
- Encodings 10-15 are unreachable; if one is ever entered, the next state is FETCH and all outputs are 0.
- Reset: when rst_n=0 at a rising edge, state <= FETCH. While rst_n=0, all control outputs are forced to 0 combinationally.
- Reset mid-instruction: abandons the instruction; the next cycle is FETCH with no register or memory write.
- Outputs are a Moore decode of state. Only irWrite, pcWrite, pc_en and illegal_op also depend on inputs.
- Any output not listed for a state is 0.

State outputs and transitions:
- FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00, irWrite=pcWrite=mem_ready. Goes to DECODE when mem_ready=1, otherwise stays in FETCH.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00.
  - lw (100011) or sw (101011) -> MEMADR
  - R-type (000000) -> EXEC
  - beq (000100) -> BRANCH
  - j (000010) -> JUMP
  - any other opcode -> FETCH, with illegal_op=1 for this cycle
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. lw -> MEMRD, sw -> MEMWR.
- MEMRD: memRead=1, iorD=1. Goes to MEMWB on mem_ready, otherwise holds.
- MEMWB: regWrite=1, memToReg=1, regDst=0. Goes to FETCH.
- MEMWR: memWrite=1, iorD=1. Goes to FETCH on mem_ready, otherwise holds; memWrite stays high while holding.
- EXEC: aluSrcA=1, aluSrcB=00, aluOp=10. Goes to ALUWB.
- ALUWB: regWrite=1, regDst=1, memToReg=0. Goes to FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01; pc_en=zero. Goes to FETCH.
- JUMP: pcWrite=1, pcSource=10. Goes to FETCH.

Timing and handshake rules:
- Latency with mem_ready held at 1: beq and j take 3 cycles, R-type and sw take 4, lw takes 5.
- Each wait cycle adds exactly one cycle.
- opcode is sampled only in DECODE and MEMADR; changes in any other state are ignored.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Simultaneous rst_n=0 and mem_ready=1: reset wins.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with mem_ready=1 -> all outputs 0, then state=0 after the edge. Release -> FETCH shows memRead=1, aluSrcB=01, pc_en=1.
- R-type (opcode 000000), mem_ready=1 -> states 0,1,6,7,0. aluOp=10 in EXEC; regWrite=1 and regDst=1 only in ALUWB; 4 cycles.
- lw (100011) with mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0. memRead and iorD stay high through the waits; regWrite and memToReg are 1 only in state 4.
- sw (101011) -> states 0,1,2,5,0, memWrite=1 only in state 5. beq (000100): zero=1 gives pc_en=1 in BRANCH; zero=0 gives pc_en=0. aluOp=01 in both cases.
- j (000010) -> pcWrite=1, pcSource=10 in JUMP. Illegal opcode 111111 -> illegal_op=1 for exactly the DECODE cycle, next state FETCH, no regWrite or memWrite.
- Reset asserted in MEMWR while mem_ready=0 -> next state is FETCH, memWrite is 0 from the reset cycle onward. Repeat with MEM_WAIT_EN=0 and mem_ready=0 -> no stall anywhere.
